// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage ALU with C/Z flags and the EX/MEM pipeline register
module ex_mem_stage #(
  parameter int WIDTH = 8,
  parameter int IW    = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ID_EX_A,
  input  logic [WIDTH-1:0] ID_EX_B,
  input  logic [IW-1:0]    ID_EX_instruction,
  input  logic             ID_EX_mem_write,
  input  logic             ID_EX_reg_write,
  input  logic             ID_EX_alu_use_carry,
  input  logic [1:0]       ID_EX_alu_in_mux,
  input  logic             ID_EX_select_c,
  input  logic             ID_EX_select_z,
  input  logic             ID_EX_write_c,
  input  logic             ID_EX_write_z,
  input  logic [2:0]       ID_EX_alu_op,
  input  logic [1:0]       ID_EX_reg_write_mux,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] EX_MEM_result,
  output logic [WIDTH-1:0] EX_MEM_B,
  output logic [IW-1:0]    EX_MEM_instruction,
  output logic             EX_MEM_mem_write,
  output logic             EX_MEM_reg_write,
  output logic [1:0]       EX_MEM_reg_write_mux,
  output logic             flag_c,
  output logic             flag_z
);
  logic [WIDTH-1:0] op2, r;
  logic [WIDTH:0]   sum, dif;
  logic             cin, co, so, zn;
  assign op2 = ID_EX_alu_in_mux == 2'b00 ? ID_EX_B :
               ID_EX_alu_in_mux == 2'b01 ? ID_EX_instruction[WIDTH-1:0] :
               ID_EX_alu_in_mux == 2'b10 ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b1}};
  assign cin = ID_EX_alu_use_carry & flag_c;
  assign sum = {1'b0, ID_EX_A} + {1'b0, op2} + {{WIDTH{1'b0}}, cin};
  // Bit WIDTH of the 9-bit difference is set exactly when A < op2 + cin, i.e. the borrow.
  assign dif = {1'b0, ID_EX_A} - {1'b0, op2} - {{WIDTH{1'b0}}, cin};
  assign zn  = r == '0;
  // ALU: result, carry/borrow out and the separate shift-out bit
  always_comb begin
    r  = '0;
    co = 1'b0;
    so = 1'b0;
    case (ID_EX_alu_op)
      3'd0: {co, r} = sum;
      3'd1: {co, r} = dif;
      3'd2: r = ID_EX_A & op2;
      3'd3: r = ID_EX_A | op2;
      3'd4: r = ID_EX_A ^ op2;
      3'd5: {so, r} = {ID_EX_A, cin};
      3'd6: {r, so} = {cin, ID_EX_A};
      default: r = op2;
    endcase
  end
  // EX/MEM register and flags: flush squashes to a bubble ahead of stall, stall holds everything
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      EX_MEM_result        <= '0;
      EX_MEM_B             <= '0;
      EX_MEM_instruction   <= '0;
      EX_MEM_mem_write     <= 1'b0;
      EX_MEM_reg_write     <= 1'b0;
      EX_MEM_reg_write_mux <= '0;
      flag_c               <= 1'b0;
      flag_z               <= 1'b0;
    end else if (flush) begin
      EX_MEM_result        <= '0;
      EX_MEM_B             <= '0;
      EX_MEM_instruction   <= '0;
      EX_MEM_mem_write     <= 1'b0;
      EX_MEM_reg_write     <= 1'b0;
      EX_MEM_reg_write_mux <= '0;
    end else if (!stall) begin
      EX_MEM_result        <= r;
      EX_MEM_B             <= ID_EX_B;
      EX_MEM_instruction   <= ID_EX_instruction;
      EX_MEM_mem_write     <= ID_EX_mem_write;
      EX_MEM_reg_write     <= ID_EX_reg_write;
      EX_MEM_reg_write_mux <= ID_EX_reg_write_mux;
      if (ID_EX_write_c) flag_c <= ID_EX_select_c ? so : co;
      if (ID_EX_write_z) flag_z <= ID_EX_select_z ? flag_z & zn : zn;
    end
  end
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed-vector self-checking bench for ex_mem_stage
module tb_ex_mem_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  a, b;
  logic [18:0] ins;
  logic        mw, rw, uc, sc, sz, wc, wz, stall, flush;
  logic [1:0]  mux, rwm;
  logic [2:0]  op;
  logic [7:0]  res, sb;
  logic [18:0] ins_q;
  logic        mw_q, rw_q, fc, fz;
  logic [1:0]  rwm_q;
  int          checks = 0;
  int          errors = 0;
  ex_mem_stage #(.WIDTH(8), .IW(19)) dut (
    .clk(clk), .reset(reset),
    .ID_EX_A(a), .ID_EX_B(b), .ID_EX_instruction(ins),
    .ID_EX_mem_write(mw), .ID_EX_reg_write(rw), .ID_EX_alu_use_carry(uc),
    .ID_EX_alu_in_mux(mux), .ID_EX_select_c(sc), .ID_EX_select_z(sz),
    .ID_EX_write_c(wc), .ID_EX_write_z(wz), .ID_EX_alu_op(op),
    .ID_EX_reg_write_mux(rwm), .stall(stall), .flush(flush),
    .EX_MEM_result(res), .EX_MEM_B(sb), .EX_MEM_instruction(ins_q),
    .EX_MEM_mem_write(mw_q), .EX_MEM_reg_write(rw_q),
    .EX_MEM_reg_write_mux(rwm_q), .flag_c(fc), .flag_z(fz)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [7:0] ia, input logic [7:0] ib, input logic [18:0] iins,
                       input logic [2:0] iop, input logic [1:0] imux, input logic iuc,
                       input logic isc, input logic isz, input logic iwc, input logic iwz,
                       input logic irw, input logic imw, input logic [1:0] irwm);
    a = ia; b = ib; ins = iins; op = iop; mux = imux; uc = iuc;
    sc = isc; sz = isz; wc = iwc; wz = iwz; rw = irw; mw = imw; rwm = irwm;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_rcz(input string tag, input logic [7:0] er, input logic ec, input logic ez);
    chk({tag, ".result"}, res, er);
    chk({tag, ".c"}, fc, ec);
    chk({tag, ".z"}, fz, ez);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, ".result"}, res, 0);
    chk({tag, ".b"}, sb, 0);
    chk({tag, ".instr"}, ins_q, 0);
    chk({tag, ".ctl"}, {mw_q, rw_q, rwm_q}, 0);
    chk({tag, ".flags"}, {fc, fz}, 0);
  endtask
  initial begin
    stall = 1'b0;
    flush = 1'b0;
    reset = 1'b1;
    drive(8'hFF, 8'h01, 19'h7FFFF, 3'd0, 2'b00, 1, 1, 0, 1, 1, 1, 1, 2'b11);
    #2;
    chk_zero("reset_async");
    tick;
    tick;
    chk_zero("reset_held");
    reset = 1'b0;
    drive(8'hFF, 8'h01, 19'h12345, 3'd0, 2'b00, 0, 0, 0, 1, 1, 1, 0, 2'b10);
    tick;
    chk_rcz("add_ff_01", 8'h00, 1, 1);
    chk("add_ff_01.b", sb, 8'h01);
    chk("add_ff_01.instr", ins_q, 19'h12345);
    chk("add_ff_01.ctl", {mw_q, rw_q, rwm_q}, 4'b0110);
    drive(8'h00, 8'h00, 19'h0, 3'd0, 2'b00, 1, 0, 0, 1, 1, 1, 0, 2'b00);
    tick;
    chk_rcz("adc_carry_in", 8'h01, 0, 0);
    drive(8'h10, 8'h55, 19'h00A20, 3'd1, 2'b01, 0, 0, 0, 1, 1, 0, 1, 2'b01);
    tick;
    chk_rcz("sub_imm_borrow", 8'hF0, 1, 0);
    chk("sub_imm_borrow.b", sb, 8'h55);
    chk("sub_imm_borrow.ctl", {mw_q, rw_q, rwm_q}, 4'b1001);
    drive(8'h00, 8'h00, 19'h0, 3'd0, 2'b00, 0, 0, 0, 1, 1, 1, 0, 2'b00);
    tick;
    chk_rcz("set_z", 8'h00, 0, 1);
    drive(8'h05, 8'h05, 19'h0, 3'd1, 2'b00, 0, 0, 1, 1, 1, 1, 0, 2'b00);
    tick;
    chk_rcz("chain_z_keep1", 8'h00, 0, 1);
    drive(8'h01, 8'h00, 19'h0, 3'd3, 2'b00, 0, 0, 0, 0, 1, 1, 0, 2'b00);
    tick;
    chk_rcz("or_clear_z", 8'h01, 0, 0);
    drive(8'h05, 8'h05, 19'h0, 3'd1, 2'b00, 0, 0, 1, 1, 1, 1, 0, 2'b00);
    tick;
    chk_rcz("chain_z_keep0", 8'h00, 0, 0);
    drive(8'hFF, 8'h01, 19'h0, 3'd0, 2'b00, 0, 0, 0, 1, 0, 1, 0, 2'b00);
    tick;
    chk_rcz("set_c", 8'h00, 1, 0);
    drive(8'h81, 8'h00, 19'h0, 3'd5, 2'b00, 1, 1, 0, 1, 0, 1, 0, 2'b00);
    tick;
    chk_rcz("shl_cin", 8'h03, 1, 0);
    drive(8'h05, 8'h05, 19'h0, 3'd1, 2'b00, 1, 0, 0, 1, 0, 1, 0, 2'b00);
    tick;
    chk_rcz("sbc_borrow", 8'hFF, 1, 0);
    drive(8'h00, 8'h00, 19'h0, 3'd0, 2'b00, 0, 0, 0, 1, 0, 1, 0, 2'b00);
    tick;
    chk_rcz("clr_c", 8'h00, 0, 0);
    drive(8'h02, 8'h00, 19'h0, 3'd6, 2'b00, 1, 1, 0, 1, 0, 1, 0, 2'b00);
    tick;
    chk_rcz("shr_02", 8'h01, 0, 0);
    drive(8'h03, 8'h00, 19'h0, 3'd6, 2'b00, 1, 1, 0, 1, 0, 1, 0, 2'b00);
    tick;
    chk_rcz("shr_03_out", 8'h01, 1, 0);
    drive(8'hF0, 8'h3C, 19'h0, 3'd2, 2'b00, 0, 0, 0, 1, 1, 1, 0, 2'b00);
    tick;
    chk_rcz("and", 8'h30, 0, 0);
    drive(8'hF0, 8'h3C, 19'h0, 3'd4, 2'b00, 0, 0, 0, 0, 0, 1, 0, 2'b00);
    tick;
    chk("xor.result", res, 8'hCC);
    drive(8'hF0, 8'h3C, 19'h0, 3'd7, 2'b10, 0, 0, 0, 0, 0, 1, 0, 2'b00);
    tick;
    chk("pass_one.result", res, 8'h01);
    drive(8'hF0, 8'h3C, 19'h0, 3'd7, 2'b11, 0, 0, 0, 0, 0, 1, 0, 2'b00);
    tick;
    chk("pass_ff.result", res, 8'hFF);
    drive(8'h12, 8'h34, 19'h00111, 3'd0, 2'b00, 0, 0, 0, 1, 1, 1, 0, 2'b01);
    tick;
    chk_rcz("pre_stall", 8'h46, 0, 0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(8'hFF, 8'h01 + 8'(i), 19'h22222, 3'd0, 2'b00, 0, 0, 0, 1, 1, 0, 1, 2'b10);
      tick;
      chk_rcz("stall_hold", 8'h46, 0, 0);
      chk("stall_hold.b", sb, 8'h34);
      chk("stall_hold.instr", ins_q, 19'h00111);
      chk("stall_hold.ctl", {mw_q, rw_q, rwm_q}, 4'b0101);
    end
    stall = 1'b0;
    drive(8'hFF, 8'h01, 19'h22222, 3'd0, 2'b00, 0, 0, 0, 1, 1, 0, 1, 2'b10);
    tick;
    chk_rcz("stall_release", 8'h00, 1, 1);
    chk("stall_release.ctl", {mw_q, rw_q, rwm_q}, 4'b1010);
    drive(8'h01, 8'h00, 19'h0, 3'd0, 2'b00, 0, 0, 0, 1, 1, 1, 0, 2'b00);
    tick;
    chk_rcz("pre_flush", 8'h01, 0, 0);
    stall = 1'b1;
    flush = 1'b1;
    drive(8'hFF, 8'h01, 19'h0, 3'd0, 2'b00, 0, 0, 0, 1, 1, 1, 1, 2'b00);
    tick;
    chk("flush_stall.ctl", {mw_q, rw_q}, 2'b00);
    chk("flush_stall.flags", {fc, fz}, 2'b00);
    stall = 1'b0;
    tick;
    chk("flush_only.ctl", {mw_q, rw_q}, 2'b00);
    chk("flush_only.flags", {fc, fz}, 2'b00);
    flush = 1'b0;
    drive(8'hFF, 8'h01, 19'h0, 3'd0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    tick;
    chk_rcz("bubble", 8'h00, 0, 0);
    chk("bubble.ctl", {mw_q, rw_q}, 2'b00);
    drive(8'hFF, 8'h02, 19'h00333, 3'd0, 2'b00, 0, 0, 0, 1, 1, 1, 1, 2'b11);
    tick;
    chk_rcz("pre_reset", 8'h01, 1, 0);
    stall = 1'b1;
    reset = 1'b1;
    #1;
    chk_zero("reset_mid");
    #1;
    reset = 1'b0;
    stall = 1'b0;
    drive(8'h01, 8'h01, 19'h0, 3'd0, 2'b00, 0, 0, 0, 1, 1, 1, 0, 2'b00);
    tick;
    chk_rcz("post_reset", 8'h02, 0, 0);
    chk("post_reset.rw", rw_q, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
